// File: rtl/mem_access_if.sv
// Bundle of the EX/MEM request, data-memory and MEM/WB result signals
// around mem_access_unit; slave is the unit's view, master the environment's.
interface mem_access_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic              in_read;
    logic              in_write;
    logic [DATA_W-1:0] in_addr;
    logic [DATA_W-1:0] in_wdata;
    logic [4:0]        in_dest;
    logic              in_wb_en;

    logic [DATA_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_read;
    logic              mem_write;
    logic [DATA_W-1:0] mem_rdata;

    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic [4:0]        out_dest;
    logic              out_wb_en;
    logic              out_misaligned;

    modport slave (
        input  in_valid, in_read, in_write, in_addr, in_wdata, in_dest, in_wb_en,
        input  mem_rdata,
        output in_ready,
        output mem_address, mem_wdata, mem_read, mem_write,
        output out_valid, out_data, out_dest, out_wb_en, out_misaligned
    );

    modport master (
        output in_valid, in_read, in_write, in_addr, in_wdata, in_dest, in_wb_en,
        output mem_rdata,
        input  in_ready,
        input  mem_address, mem_wdata, mem_read, mem_write,
        input  out_valid, out_data, out_dest, out_wb_en, out_misaligned
    );
endinterface

// File: rtl/mem_access_unit.sv
// Memory-stage access controller: holds read/write strobes for LATENCY cycles
// and retires loads, stores and ALU pass-through ops. Optional: MEM_ALIGN_CHECK_EN.
module mem_access_unit #(
    parameter int DATA_W    = 32,
    parameter int MEM_WORDS = 2048,
    parameter int LATENCY   = 2
) (
    input logic         clk,
    input logic         rst,
    mem_access_if.slave bus
);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [4:0]        r_dest;
    logic              r_wb_en;
    logic              r_is_store;

    logic [DATA_W-1:0] r_mem_address;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_mem_read;
    logic              r_mem_write;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic [4:0]        r_out_dest;
    logic              r_out_wb_en;
    logic              r_out_misaligned;

    logic              w_accept;
    logic              w_mem_op;
    logic              w_misaligned;
    logic [DATA_W-1:0] w_word_idx;

    assign w_accept   = bus.in_valid && (r_state == IDLE);
    assign w_mem_op   = bus.in_read || bus.in_write;
    // Byte address to word index; indices beyond the memory wrap around.
    assign w_word_idx = (bus.in_addr >> 2) & DATA_W'(MEM_WORDS - 1);

`ifdef MEM_ALIGN_CHECK_EN
    assign w_misaligned = w_mem_op && (bus.in_addr[1:0] != 2'b00);
`else
    assign w_misaligned = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= IDLE;
            r_cnt            <= '0;
            r_mem_address    <= '0;
            r_mem_wdata      <= '0;
            r_mem_read       <= 1'b0;
            r_mem_write      <= 1'b0;
            r_out_valid      <= 1'b0;
            r_out_data       <= '0;
            r_out_dest       <= '0;
            r_out_wb_en      <= 1'b0;
            r_out_misaligned <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        // Pass-through and rejected misaligned ops retire without touching memory.
                        if (!w_mem_op || w_misaligned) begin
                            r_out_valid      <= 1'b1;
                            r_out_data       <= bus.in_addr;
                            r_out_dest       <= bus.in_dest;
                            r_out_wb_en      <= bus.in_wb_en & ~w_misaligned;
                            r_out_misaligned <= w_misaligned;
                        end else begin
                            r_dest        <= bus.in_dest;
                            r_wb_en       <= bus.in_wb_en;
                            r_is_store    <= bus.in_write;
                            r_mem_address <= w_word_idx;
                            r_mem_wdata   <= bus.in_wdata;
                            r_mem_write   <= bus.in_write;
                            r_mem_read    <= ~bus.in_write;
                            r_cnt         <= CNT_W'(LATENCY - 1);
                            r_state       <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_mem_read       <= 1'b0;
                        r_mem_write      <= 1'b0;
                        r_out_valid      <= 1'b1;
                        r_out_data       <= r_is_store ? '0 : bus.mem_rdata;
                        r_out_dest       <= r_dest;
                        r_out_wb_en      <= r_is_store ? 1'b0 : r_wb_en;
                        r_out_misaligned <= 1'b0;
                        r_state          <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready       = (r_state == IDLE);
    assign bus.mem_address    = r_mem_address;
    assign bus.mem_wdata      = r_mem_wdata;
    assign bus.mem_read       = r_mem_read;
    assign bus.mem_write      = r_mem_write;
    assign bus.out_valid      = r_out_valid;
    assign bus.out_data       = r_out_data;
    assign bus.out_dest       = r_out_dest;
    assign bus.out_wb_en      = r_out_wb_en;
    assign bus.out_misaligned = r_out_misaligned;
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed scenarios plus random instruction stream
// against a cycle-indexed expectation model and an array-backed data memory.
module tb_mem_access_unit;
    localparam int DATA_W    = 32;
    localparam int MEM_WORDS = 2048;
    localparam int LATENCY   = 2;
    localparam int AW        = $clog2(MEM_WORDS);
`ifdef MEM_ALIGN_CHECK_EN
    localparam bit ALIGN_CHK = 1'b1;
`else
    localparam bit ALIGN_CHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_access_if #(.DATA_W(DATA_W)) bus ();

    mem_access_unit #(
        .DATA_W(DATA_W), .MEM_WORDS(MEM_WORDS), .LATENCY(LATENCY)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    logic [31:0] tb_mem    [MEM_WORDS];
    logic [31:0] model_mem [MEM_WORDS];

    assign bus.mem_rdata = tb_mem[bus.mem_address[AW-1:0]];
    always @(posedge clk) if (bus.mem_write === 1'b1) tb_mem[bus.mem_address[AW-1:0]] <= bus.mem_wdata;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  dest;
        logic        wb;
        logic        mis;
    } ret_t;

    // Expectations keyed by cycle number (cycle k = interval after the k-th rising edge).
    ret_t        ev [int];
    bit          sr [int];
    bit          sw [int];
    bit          rl [int];
    bit          rstev [int];
    logic [31:0] saddr [int];
    logic [31:0] swd [int];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%b want=%b", name, cyc, act, exp);
        end
    endtask

    logic [31:0] h_data = '0, h_addr = '0, h_wd = '0;
    logic [4:0]  h_dest = '0;
    logic        h_wb = 1'b0, h_mis = 1'b0;

    always @(negedge clk) begin : cmp
        int c;
        if (chk_en) begin
            c = cyc;
            if (rstev.exists(c)) begin
                h_data = '0; h_addr = '0; h_wd = '0; h_dest = '0; h_wb = 1'b0; h_mis = 1'b0;
            end
            if (ev.exists(c)) begin
                h_data = ev[c].data; h_dest = ev[c].dest; h_wb = ev[c].wb; h_mis = ev[c].mis;
            end
            if (sr.exists(c) || sw.exists(c)) begin
                h_addr = saddr[c]; h_wd = swd[c];
            end
            chk1("out_valid", bus.out_valid, ev.exists(c) != 0);
            chk1("in_ready", bus.in_ready, rl.exists(c) == 0);
            chk1("mem_read", bus.mem_read, sr.exists(c) != 0);
            chk1("mem_write", bus.mem_write, sw.exists(c) != 0);
            chk("out_data", bus.out_data, h_data);
            chk("out_dest", 32'(bus.out_dest), 32'(h_dest));
            chk1("out_wb_en", bus.out_wb_en, h_wb);
            chk1("out_misaligned", bus.out_misaligned, h_mis);
            chk("mem_address", bus.mem_address, h_addr);
            chk("mem_wdata", bus.mem_wdata, h_wd);
        end
    end

    // Record what an instruction accepted at edge a must produce.
    task automatic record(input int a, input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [4:0] dest, input logic wb);
        int idx;
        if (!(rd || wr)) begin
            ev[a] = '{addr, dest, wb, 1'b0};
        end else if (ALIGN_CHK && addr[1:0] != 2'b00) begin
            ev[a] = '{addr, dest, 1'b0, 1'b1};
        end else begin
            idx = int'((addr / 4) % MEM_WORDS);
            for (int i = 0; i < LATENCY; i++) begin
                rl[a+i] = 1'b1;
                if (wr) sw[a+i] = 1'b1;
                else    sr[a+i] = 1'b1;
                saddr[a+i] = 32'(idx);
                swd[a+i]   = wd;
            end
            if (wr) begin
                model_mem[idx] = wd;
                ev[a+LATENCY]  = '{32'h0, dest, 1'b0, 1'b0};
            end else begin
                ev[a+LATENCY]  = '{model_mem[idx], dest, wb, 1'b0};
            end
        end
    endtask

    // Called at #1 after an edge; returns at #1 after the accepting edge.
    task automatic send(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [4:0] dest, input logic wb);
        bit acc;
        bus.in_valid = 1'b1; bus.in_read = rd; bus.in_write = wr;
        bus.in_addr = addr; bus.in_wdata = wd; bus.in_dest = dest; bus.in_wb_en = wb;
        acc = 1'b0;
        for (int k = 0; k < 20 && !acc; k++) begin
            acc = (rl.exists(cyc) == 0);
            if (acc) record(cyc + 1, rd, wr, addr, wd, dest, wb);
            @(posedge clk); #1;
        end
        if (!acc) begin
            checks++; errors++;
            $display("FAIL accept_timeout cyc=%0d got=no_accept want=accept", cyc);
        end
    endtask

    task automatic idle();
        bus.in_valid = 1'b0; bus.in_read = 1'b0; bus.in_write = 1'b0;
        bus.in_addr = '0; bus.in_wdata = '0; bus.in_dest = '0; bus.in_wb_en = 1'b0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic do_reset(input int n);
        int c;
        rst = 1'b1;
        idle();
        c = cyc;
        for (int k = c + 1; k <= c + LATENCY + 4; k++) begin
            if (ev.exists(k))    ev.delete(k);
            if (sr.exists(k))    sr.delete(k);
            if (sw.exists(k))    sw.delete(k);
            if (rl.exists(k))    rl.delete(k);
            if (saddr.exists(k)) saddr.delete(k);
            if (swd.exists(k))   swd.delete(k);
        end
        for (int i = 1; i <= n; i++) rstev[c+i] = 1'b1;
        repeat (n) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        int r;
        for (int i = 0; i < MEM_WORDS; i++) begin
            tb_mem[i] = $urandom; model_mem[i] = tb_mem[i];
        end
        tb_mem[5] = 32'hDEADBEEF; model_mem[5] = 32'hDEADBEEF;
        idle();

        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk1("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out_data", bus.out_data, 32'h0);
        chk("rst_out_dest", 32'(bus.out_dest), 32'h0);
        chk1("rst_out_wb_en", bus.out_wb_en, 1'b0);
        chk1("rst_out_mis", bus.out_misaligned, 1'b0);
        chk("rst_mem_address", bus.mem_address, 32'h0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
        chk1("rst_mem_read", bus.mem_read, 1'b0);
        chk1("rst_mem_write", bus.mem_write, 1'b0);
        chk1("rst_in_ready", bus.in_ready, 1'b1);
        rst = 1'b0;
        chk_en = 1'b1;
        step();

        // Load of word 5
        send(1'b1, 1'b0, 32'd20, 32'h0, 5'd7, 1'b1); idle();
        chk1("ld_rd0", bus.mem_read, 1'b1);
        chk("ld_addr0", bus.mem_address, 32'd5);
        chk1("ld_rdy0", bus.in_ready, 1'b0);
        step();
        chk1("ld_rd1", bus.mem_read, 1'b1);
        chk("ld_addr1", bus.mem_address, 32'd5);
        step();
        chk1("ld_valid", bus.out_valid, 1'b1);
        chk("ld_data", bus.out_data, 32'hDEADBEEF);
        chk("ld_dest", 32'(bus.out_dest), 32'd7);
        chk1("ld_wb", bus.out_wb_en, 1'b1);
        chk1("ld_rd_off", bus.mem_read, 1'b0);
        chk1("ld_rdy_back", bus.in_ready, 1'b1);

        // Store then load back
        send(1'b0, 1'b1, 32'd8, 32'h1234, 5'd3, 1'b1); idle();
        chk1("st_wr0", bus.mem_write, 1'b1);
        chk("st_addr", bus.mem_address, 32'd2);
        step();
        chk1("st_wr1", bus.mem_write, 1'b1);
        step();
        chk1("st_valid", bus.out_valid, 1'b1);
        chk1("st_wb", bus.out_wb_en, 1'b0);
        chk1("st_wr_off", bus.mem_write, 1'b0);
        send(1'b1, 1'b0, 32'd8, 32'h0, 5'd4, 1'b1); idle();
        repeat (LATENCY) step();
        chk("ldst_data", bus.out_data, 32'h1234);

        // Back-to-back pass-through
        send(1'b0, 1'b0, 32'd1, 32'h0, 5'd9, 1'b1);
        chk("pt_data1", bus.out_data, 32'd1);
        chk1("pt_rdy1", bus.in_ready, 1'b1);
        send(1'b0, 1'b0, 32'd2, 32'h0, 5'd9, 1'b1);
        chk("pt_data2", bus.out_data, 32'd2);
        chk1("pt_valid2", bus.out_valid, 1'b1);
        send(1'b0, 1'b0, 32'd3, 32'h0, 5'd9, 1'b1); idle();
        chk("pt_data3", bus.out_data, 32'd3);
        chk1("pt_valid3", bus.out_valid, 1'b1);
        step();
        chk1("pt_valid_off", bus.out_valid, 1'b0);
        chk("pt_hold", bus.out_data, 32'd3);

        // Address wrap
        send(1'b1, 1'b0, 32'(4 * MEM_WORDS + 4), 32'h0, 5'd1, 1'b1); idle();
        chk("wrap_addr", bus.mem_address, 32'd1);
        repeat (LATENCY) step();

        // Reset during ACCESS
        send(1'b1, 1'b0, 32'd40, 32'h0, 5'd5, 1'b1); idle();
        chk1("ab_rd", bus.mem_read, 1'b1);
        do_reset(1);
        chk1("ab_rd_off", bus.mem_read, 1'b0);
        chk1("ab_valid0", bus.out_valid, 1'b0);
        chk1("ab_rdy", bus.in_ready, 1'b1);
        step();
        chk1("ab_valid1", bus.out_valid, 1'b0);

        // Misaligned store
        send(1'b0, 1'b1, 32'd6, 32'h55, 5'd2, 1'b1); idle();
        if (ALIGN_CHK) begin
            chk1("mis_valid", bus.out_valid, 1'b1);
            chk1("mis_flag", bus.out_misaligned, 1'b1);
            chk1("mis_wb", bus.out_wb_en, 1'b0);
            chk("mis_data", bus.out_data, 32'd6);
            chk1("mis_wr0", bus.mem_write, 1'b0);
            step();
            chk1("mis_wr1", bus.mem_write, 1'b0);
        end else begin
            chk1("mis_wr", bus.mem_write, 1'b1);
            chk("mis_addr", bus.mem_address, 32'd1);
            repeat (LATENCY) step();
            chk1("mis_valid", bus.out_valid, 1'b1);
        end
        step();

        // Random instruction stream
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 99) == 0) do_reset(1);
            if ($urandom_range(0, 2) == 0) begin
                idle();
                repeat ($urandom_range(1, 3)) step();
            end
            r = $urandom_range(0, 9);
            if (r < 4) begin
                send(1'b0, 1'b0, $urandom, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
            end else begin
                a = 32'($urandom_range(0, 31)) * 4;
                if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
                a = a + 32'($urandom_range(0, 3)) * 32'(MEM_WORDS * 4);
                send(r == 9 || r < 7 ? 1'b1 : 1'b0, r >= 7 ? 1'b1 : 1'b0, a, $urandom,
                     5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
            end
        end
        idle();
        repeat (LATENCY + 3) step();
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage access controller placed between the EX/MEM pipeline register and the word-addressed data memory. Converts the ALU byte address to a word index and drives the memory's level-sensitive read and write strobes for a fixed number of cycles. Captures load data and presents the retired result, destination register and write-back enable to the MEM/WB stage. Stalls upstream through a ready handshake while an access is in flight.

## Interface
- DATA_W, 32, data and address width
- MEM_WORDS, 2048, memory depth in words; power of two
- LATENCY, 2, cycles the strobe is held before load data is sampled; must be ≥1
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- in_valid  in  1  EX/MEM holds a valid instruction
- in_ready  out  1  unit accepts the instruction this cycle; equals (state==IDLE)
- in_read / in_write  in  1 each  load / store request
- in_addr  in  DATA_W  ALU result: byte address for memory ops, result value otherwise
- in_wdata  in  DATA_W  store data
- in_dest  in  5  destination register
- in_wb_en  in  1  write-back enable
- mem_address  out  DATA_W  word index to memory, registered
- mem_wdata  out  DATA_W  store data to memory, registered
- mem_read / mem_write  out  1 each  memory strobes, registered
- mem_rdata  in  DATA_W  memory read data
- out_valid  out  1  one-cycle pulse per retired instruction
- out_data  out  DATA_W  load data or pass-through ALU result
- out_dest  out  5  destination register
- out_wb_en  out  1  write-back enable to MEM/WB
- out_misaligned  out  1  misaligned memory-op flag

## Operation
- Acceptance: on any clock edge with in_valid & in_ready.
- FSM states: IDLE, ACCESS.
- IDLE, non-memory op (in_read=in_write=0):
  - At the acceptance edge: out_valid=1, out_data=in_addr, out_dest/out_wb_en copied.
  - State stays IDLE. One instruction per cycle, no stall.
- IDLE, memory op:
  - Latch dest, wb_en and op.
  - mem_address = (in_addr>>2) & (MEM_WORDS-1). Out-of-range indices wrap modulo MEM_WORDS.
  - mem_wdata = in_wdata.
  - Assert mem_write if in_write, otherwise assert mem_read. When both are set, the write wins and the read is dropped.
  - cnt = LATENCY-1; state goes to ACCESS.
- ACCESS:
  - Strobes and address are held constant.
  - cnt>0: decrement.
  - cnt==0:
    - Deassert the strobe.
    - Load: out_data=mem_rdata, out_wb_en=latched wb_en.
    - Store: out_data=0, out_wb_en=0.
    - out_valid=1; state goes to IDLE.
- out_valid clears on the next edge unless another instruction retires. out_data, out_dest and out_wb_en hold their last values.
- Reset: state=IDLE, cnt=0. Every output register is 0: mem_address, mem_wdata, mem_read, mem_write, out_valid, out_data, out_dest, out_wb_en, out_misaligned. in_ready=1 during and after reset. Reset during ACCESS aborts the access: the strobe is low after that edge, and no out_valid is produced for the aborted op.

## Timing
- Non-memory op: out_valid one cycle after the acceptance edge.
- Memory op:
  - Strobes high for exactly LATENCY cycles starting the cycle after acceptance.
  - out_valid asserted LATENCY cycles after the acceptance edge.
  - in_ready is low for LATENCY cycles and returns high in the same cycle as out_valid.
  - A following instruction can be accepted at that edge.
  - Throughput: one memory op per LATENCY+1 cycles.
- mem_rdata is sampled only at the cnt==0 edge. The memory read is combinational, so the data is stable by then.

## Configuration
- MEM_ALIGN_CHECK_EN defined, memory op with in_addr[1:0]≠0:
  - No strobe is issued; state stays IDLE.
  - Next cycle: out_valid=1, out_misaligned=1, out_wb_en=0, out_data=in_addr.
  - out_misaligned clears on the next retirement.
- MEM_ALIGN_CHECK_EN undefined:
  - in_addr[1:0] is ignored (the address is truncated).
  - out_misaligned is tied to 0.

## Test plan
- Reset check: rst high 2 cycles -> every output 0, in_ready=1.
- Load, LATENCY=2:
  - Memory word 5 = 32'hDEADBEEF; accept in_read, in_addr=20.
  - Expect mem_address=5 and mem_read=1 for 2 cycles.
  - Then out_valid pulse with out_data=32'hDEADBEEF, out_dest passed through.
- Store then load:
  - Store in_addr=8, in_wdata=32'h1234 -> mem_write high 2 cycles, out_wb_en=0.
  - Load from addr 8 -> out_data=32'h1234.
- Pass-through:
  - Three back-to-back ALU ops with in_addr=1,2,3 -> out_valid high 3 consecutive cycles, out_data=1,2,3, in_ready constantly 1.
- Wrap and abort:
  - Load with in_addr=4*MEM_WORDS+4 -> mem_address=1.
  - Reset asserted mid-ACCESS -> strobes low next cycle, no out_valid.
- Misalignment, in_addr=6 store:
  - With MEM_ALIGN_CHECK_EN: out_misaligned=1, mem_write never asserted.
  - Without it: mem_address=1 and the write occurs.
